// File: rtl/dequant_expand.sv
// ---------------------------------------------------------------------------
// dequant_expand
//   Expands unsigned quantized activations into signed wide fixed-point
//   values for the next accumulation stage:
//     out = round((q - ZERO_POINT) * scale / 2^SHIFT)
//   scale is SCALE1/SCALE2/SCALE3 for select 00/01/10, identity (2^SHIFT)
//   for select 11. Rounding is half toward +inf (add half, arithmetic shift).
//
//   Three-stage pipeline (diff/scale -> product -> round/narrow) with a
//   per-vector element counter that tags the final element of each
//   VEC_LEN-element vector on out_last.
//
//   Optional feature macro: DEQUANT_SAT_EN
//     defined   : rounded result is clamped to the signed BITWIDTH_OUT range
//     undefined : rounded result is truncated (two's-complement wrap)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   select     in   [1:0] scale select, sampled with each accepted input
//   in_data    in   [BITWIDTH_IN-1:0] unsigned quantized value
//   in_valid   in   input valid
//   in_ready   out  input ready
//   out_data   out  [BITWIDTH_OUT-1:0] signed dequantized value
//   out_valid  out  output valid
//   out_ready  in   downstream ready
//   out_last   out  final element of a VEC_LEN vector
//
// Handshake: a transfer happens on a rising edge where valid && ready.
//   advance = !out_valid || out_ready moves all three stages together and
//   is presented combinationally as in_ready. While out_valid && !out_ready
//   every stage holds, so out_data/out_last stay stable. Bubbles travel
//   through the pipeline; they are not collapsed.
// ---------------------------------------------------------------------------
module dequant_expand #(
    parameter int BITWIDTH_IN    = 8,
    parameter int BITWIDTH_OUT   = 16,
    parameter int BITWIDTH_SCALE = 16,
    parameter int SHIFT          = 8,
    parameter int ZERO_POINT     = 128,
    parameter int SCALE1         = 199,
    parameter int SCALE2         = 156,
    parameter int SCALE3         = 164,
    parameter int VEC_LEN        = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              select,
    input  logic [BITWIDTH_IN-1:0]  in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [BITWIDTH_OUT-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last
);

    localparam int DW = BITWIDTH_IN + 1;                  // signed diff
    localparam int PW = BITWIDTH_IN + BITWIDTH_SCALE + 2; // full product
    localparam int RW = PW + 1;                           // product + round
    localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    localparam logic [BITWIDTH_IN-1:0]    ZP     = BITWIDTH_IN'(ZERO_POINT);
    localparam logic [BITWIDTH_SCALE-1:0] SC1    = BITWIDTH_SCALE'(SCALE1);
    localparam logic [BITWIDTH_SCALE-1:0] SC2    = BITWIDTH_SCALE'(SCALE2);
    localparam logic [BITWIDTH_SCALE-1:0] SC3    = BITWIDTH_SCALE'(SCALE3);
    localparam logic [BITWIDTH_SCALE-1:0] SC_ID  = BITWIDTH_SCALE'(2**SHIFT);
    localparam logic [CW-1:0]             CNT_LAST = CW'(VEC_LEN - 1);
    localparam logic signed [RW-1:0]      RND    = RW'(2**(SHIFT-1));
`ifdef DEQUANT_SAT_EN
    localparam logic signed [RW-1:0]      OMAX   = RW'(2**(BITWIDTH_OUT-1) - 1);
    localparam logic signed [RW-1:0]      OMIN   = -OMAX - RW'(1);
`endif

    logic advance;
    logic accept;

    // element counter within the current vector
    logic [CW-1:0] cnt;

    // stage 1 registers
    logic                      s1_valid;
    logic signed [DW-1:0]      s1_diff;
    logic [BITWIDTH_SCALE-1:0] s1_scale;
    logic                      s1_last;

    // stage 2 registers
    logic                      s2_valid;
    logic signed [PW-1:0]      s2_prod;
    logic                      s2_last;

    // combinational stage inputs
    logic signed [DW-1:0]      diff_c;
    logic [BITWIDTH_SCALE-1:0] scale_c;
    logic                      last_c;
    logic signed [PW-1:0]      prod_c;
    logic signed [RW-1:0]      sum_c;
    logic signed [RW-1:0]      r_c;
    logic [BITWIDTH_OUT-1:0]   narrow_c;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance;

    // stage 1: zero-point removal and scale lookup
    assign diff_c = $signed({1'b0, in_data}) - $signed({1'b0, ZP});
    assign last_c = (cnt == CNT_LAST);

    always_comb begin
        scale_c = SC_ID;
        case (select)
            2'b00:   scale_c = SC1;
            2'b01:   scale_c = SC2;
            2'b10:   scale_c = SC3;
            default: scale_c = SC_ID;
        endcase
    end

    // stage 2: full-width signed product; the scale is zero-extended so it
    // is never interpreted as negative
    assign prod_c = PW'(s1_diff) * PW'($signed({1'b0, s1_scale}));

    // stage 3: round half toward +inf, then narrow
    assign sum_c = RW'(s2_prod) + RND;
    assign r_c   = sum_c >>> SHIFT;

`ifdef DEQUANT_SAT_EN
    always_comb begin
        narrow_c = BITWIDTH_OUT'(r_c);
        if (r_c > OMAX)
            narrow_c = BITWIDTH_OUT'(OMAX);
        else if (r_c < OMIN)
            narrow_c = BITWIDTH_OUT'(OMIN);
    end
`else
    assign narrow_c = BITWIDTH_OUT'(r_c);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            s1_valid  <= 1'b0;
            s1_diff   <= '0;
            s1_scale  <= '0;
            s1_last   <= 1'b0;
            s2_valid  <= 1'b0;
            s2_prod   <= '0;
            s2_last   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (accept)
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            if (advance) begin
                // in_valid here equals accept, so bubbles enter as invalid
                s1_valid  <= in_valid;
                s1_diff   <= diff_c;
                s1_scale  <= scale_c;
                s1_last   <= last_c && in_valid;
                s2_valid  <= s1_valid;
                s2_prod   <= prod_c;
                s2_last   <= s1_last;
                out_valid <= s2_valid;
                out_data  <= narrow_c;
                out_last  <= s2_last;
            end
        end
    end

endmodule

// File: tb/tb_dequant_expand.sv
// ---------------------------------------------------------------------------
// tb_dequant_expand
//   Three DUT instances share one stimulus stream:
//     a : default parameters
//     b : VEC_LEN = 4 (vector framing)
//     c : BITWIDTH_OUT = 12, SCALE1 = 65535 (saturation / wrap)
//   A behavioural model computes each expected output from the arithmetic
//   definition and queues it on accept; a compare process pops and checks
//   on every consume. Directed literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_dequant_expand;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  select = 2'b00;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready_a, in_ready_b, in_ready_c;
    logic [15:0] out_data_a, out_data_b;
    logic [11:0] out_data_c;
    logic        out_valid_a, out_valid_b, out_valid_c;
    logic        out_last_a, out_last_b, out_last_c;

    int n_vec  = 0;
    int n_fail = 0;

    // model state
    logic [16:0] exp_a[$];
    logic [16:0] exp_b[$];
    logic [12:0] exp_c[$];
    int          idx = 0;       // accepts since reset
    int          b_pos = 0;     // outputs of b since reset
    bit          framing = 1'b0;
    bit          prev_stall = 1'b0;
    logic [15:0] held_a, held_b;
    logic [11:0] held_c;
    logic        held_last_b;

    always #5 clk = ~clk;

    dequant_expand u_a (
        .clk(clk), .rst(rst), .select(select), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready_a), .out_data(out_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_last(out_last_a)
    );

    dequant_expand #(.VEC_LEN(4)) u_b (
        .clk(clk), .rst(rst), .select(select), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready_b), .out_data(out_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_last(out_last_b)
    );

    dequant_expand #(.BITWIDTH_OUT(12), .SCALE1(65535)) u_c (
        .clk(clk), .rst(rst), .select(select), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready_c), .out_data(out_data_c),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_last(out_last_c)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // round((q-128)*scale/256), half toward +inf, narrowed to bw bits
    function automatic longint model(input int q, input int sel, input longint sc1, input int bw);
        longint diff, sc, r;
        diff = longint'(q) - 128;
        case (sel)
            0:       sc = sc1;
            1:       sc = 156;
            2:       sc = 164;
            default: sc = 256;
        endcase
        r = (diff * sc + 128) >>> 8;
`ifdef DEQUANT_SAT_EN
        if (r > (longint'(1) <<< (bw-1)) - 1) r = (longint'(1) <<< (bw-1)) - 1;
        if (r < -(longint'(1) <<< (bw-1)))    r = -(longint'(1) <<< (bw-1));
`else
        r = r & ((longint'(1) <<< bw) - 1);
        if (r >= (longint'(1) <<< (bw-1))) r = r - (longint'(1) <<< bw);
`endif
        return r;
    endfunction

    // compare process: sampled on the falling edge, inputs change after posedge
    always @(negedge clk) begin
        logic [16:0] e;
        logic [12:0] ec;
        if (rst) begin
            exp_a.delete();
            exp_b.delete();
            exp_c.delete();
            idx        = 0;
            b_pos      = 0;
            prev_stall = 1'b0;
        end else begin
            check("in_ready_a", longint'(in_ready_a), longint'(!out_valid_a || out_ready));
            check("in_ready_c", longint'(in_ready_c), longint'(!out_valid_c || out_ready));
            if (prev_stall) begin
                check("hold_a", longint'($signed(out_data_a)), longint'($signed(held_a)));
                check("hold_b", longint'($signed(out_data_b)), longint'($signed(held_b)));
                check("hold_c", longint'($signed(out_data_c)), longint'($signed(held_c)));
                check("hold_last_b", longint'(out_last_b), longint'(held_last_b));
            end
            if (out_valid_a && out_ready) begin
                if (exp_a.size() == 0) check("a_unexpected", 1, 0);
                else begin
                    e = exp_a.pop_front();
                    check("a_data", longint'($signed(out_data_a)), longint'($signed(e[15:0])));
                    check("a_last", longint'(out_last_a), longint'(e[16]));
                end
            end
            if (out_valid_b && out_ready) begin
                b_pos++;
                if (exp_b.size() == 0) check("b_unexpected", 1, 0);
                else begin
                    e = exp_b.pop_front();
                    check("b_data", longint'($signed(out_data_b)), longint'($signed(e[15:0])));
                    check("b_last", longint'(out_last_b), longint'(e[16]));
                end
                if (framing)
                    check("b_frame_last", longint'(out_last_b), longint'(b_pos == 4 || b_pos == 8));
            end
            if (out_valid_c && out_ready) begin
                if (exp_c.size() == 0) check("c_unexpected", 1, 0);
                else begin
                    ec = exp_c.pop_front();
                    check("c_data", longint'($signed(out_data_c)), longint'($signed(ec[11:0])));
                    check("c_last", longint'(out_last_c), longint'(ec[12]));
                end
            end
            if (in_valid && in_ready_a) begin
                exp_a.push_back({(idx % 64) == 63, 16'(model(int'(in_data), int'(select), 199, 16))});
                exp_b.push_back({(idx % 4) == 3,   16'(model(int'(in_data), int'(select), 199, 16))});
                exp_c.push_back({(idx % 64) == 63, 12'(model(int'(in_data), int'(select), 65535, 12))});
                idx++;
            end
            prev_stall  = out_valid_a && !out_ready;
            held_a      = out_data_a;
            held_b      = out_data_b;
            held_c      = out_data_c;
            held_last_b = out_last_b;
        end
    end

    // present one element and hold it until accepted (bounded)
    task automatic send(input logic [7:0] q, input logic [1:0] s);
        bit got;
        got      = 1'b0;
        in_data  = q;
        select   = s;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready_a) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // reset values
        @(negedge clk);
        check("rst_out_valid", longint'(out_valid_a), 0);
        check("rst_out_data", longint'(out_data_a), 0);
        check("rst_out_last", longint'(out_last_b), 0);
        check("rst_in_ready", longint'(in_ready_a), 1);

        // basic: q=255 then q=0, select 00, latency 3
        @(posedge clk); #1;
        in_data = 8'd255; select = 2'b00; in_valid = 1'b1;
        @(negedge clk);                       // accept 255
        @(posedge clk); #1;
        in_data = 8'd0;
        @(negedge clk);                       // accept 0
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_not_yet", longint'(out_valid_a), 0);
        @(negedge clk);
        check("lat_valid", longint'(out_valid_a), 1);
        check("basic_pos", longint'($signed(out_data_a)), 99);
`ifdef DEQUANT_SAT_EN
        check("sat_pos", longint'($signed(out_data_c)), 2047);
`else
        // 127*65535 = 8322945; (8322945+128)>>8 = 32512 = 0x7F00; low 12 bits 0xF00
        check("wrap_pos", longint'($signed(out_data_c)), -256);
`endif
        @(negedge clk);
        check("basic_neg", longint'($signed(out_data_a)), -99);
`ifdef DEQUANT_SAT_EN
        check("sat_neg", longint'($signed(out_data_c)), -2048);
`else
        check("wrap_neg", longint'($signed(out_data_c)), 1);
`endif

        // identity sweep, full rate
        @(posedge clk); #1;
        for (int q = 0; q < 256; q++) send(8'(q), 2'b11);
        repeat (5) @(posedge clk);
        #1;

        // backpressure mid-stream
        fork
            begin
                for (int i = 0; i < 10; i++) send(8'(i * 25 + 3), 2'(i % 4));
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (5) @(posedge clk);
        #1;

        // vector framing with random gaps and random backpressure
        do_reset();
        framing = 1'b1;
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    send(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
            end
            begin
                repeat (30) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        check("frame_count", longint'(b_pos), 9);
        framing = 1'b0;

        // reset with three elements in flight
        out_ready = 1'b0;
        send(8'd200, 2'b00);
        send(8'd10, 2'b01);
        send(8'd77, 2'b10);
        check("inflight_valid", longint'(out_valid_a), 1);
        check("inflight_stall", longint'(in_ready_a), 0);
        #2 rst = 1'b1;
        #1;
        check("rst_async_a", longint'(out_valid_a), 0);
        check("rst_async_b", longint'(out_valid_b), 0);
        check("rst_async_c", longint'(out_valid_c), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(8'(60 + i * 40), 2'b00);
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_count_b", longint'(b_pos), 5);

        // everything accepted must have come out
        check("drain_a", longint'(exp_a.size()), 0);
        check("drain_b", longint'(exp_b.size()), 0);
        check("drain_c", longint'(exp_c.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
